fifo_write_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the single write port of one repacketizer FIFO between N_REQ byte-stream requesters.
- For each granted packet it writes a one-word header (marker plus requester ID), then the payload, and tags the final word with a last flag.
- Sits entirely in the FIFO write-clock domain, directly in front of the FIFO's data_in/enable_in/full_in. The FIFO is instantiated with width DATA_WIDTH+1.

---
 rtl/fifo_write_arbiter_pkg.sv | 28 ++
 rtl/fifo_write_arbiter_if.sv | 23 ++
 rtl/fifo_write_arbiter_rr_arbiter.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding, header layout
// and width helpers.
package fifo_write_arbiter_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_HDR  = 2'd1;
  localparam logic [STATE_W-1:0] ST_XFER = 2'd2;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Requester ID width; never collapses below one bit.
  function automatic int unsigned idw_f(input int unsigned n);
    return (n < 2) ? 1 : clog2_f(n);
  endfunction

  // Header marker sits in the top payload bit so it can be told apart from the ID.
  function automatic int unsigned marker_pos_f(input int unsigned dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester stream and FIFO write-port signals shared by the arbiter and its neighbours.
interface fifo_write_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_ready;
  logic [DATA_WIDTH:0]         fifo_data;
  logic                        fifo_enable;
  logic                        fifo_full;

  modport slave (
    input  req_data, req_valid, req_last, fifo_full,
    output req_ready, fifo_data, fifo_enable
  );

  modport master (
    output req_data, req_valid, req_last, fifo_full,
    input  req_ready, fifo_data, fifo_enable
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// Combinational round-robin search: first valid requester after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   ptr,
  output logic             found_c,
  output logic [IDW-1:0]   index_c
);

  int unsigned    cand;
  logic [IDW-1:0] cidx;

  always_comb begin
    found_c = 1'b0;
    index_c = '0;
    cand    = 0;
    cidx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      cidx = IDW'(cand);
      if (!found_c && valid[cidx]) begin
        found_c = 1'b1;
        index_c = cidx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port between requesters;
// each packet is framed by a marker/ID header and a last flag on its final word.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned DATA_WIDTH  = 8,
  parameter  int unsigned MAX_PKT_LEN = 64,
  localparam int unsigned IDW         = idw_f(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fifo_write_arbiter_if.slave   bus,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  overlong
);

  localparam int unsigned CW = idw_f(MAX_PKT_LEN + 1);

  logic [STATE_W-1:0]  state, state_nxt;
  logic [IDW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]      grant_nxt;
  logic [CW-1:0]       count, count_nxt;
  logic                overlong_nxt;
  logic                found_c;
  logic [IDW-1:0]      index_c;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [DATA_WIDTH:0]   hdr_word;
  logic                lastw;
  logic                xfer;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .valid   (bus.req_valid),
    .ptr     (rr_ptr),
    .found_c (found_c),
    .index_c (index_c)
  );

  // Header word: marker bit set, granted ID in the low bits, last flag clear.
  always_comb begin
    hdr_word                              = '0;
    hdr_word[marker_pos_f(DATA_WIDTH)]    = 1'b1;
    hdr_word[IDW-1:0]                     = grant_id;
  end

  assign cur_data = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign lastw    = bus.req_last[grant_id] | (count == CW'(MAX_PKT_LEN - 1));
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    grant_nxt       = grant_id;
    count_nxt       = count;
    overlong_nxt    = 1'b0;
    xfer            = 1'b0;
    bus.req_ready   = '0;
    bus.fifo_enable = 1'b0;
    bus.fifo_data   = '0;

    case (state)
      ST_IDLE: begin
        if (found_c) begin
          grant_nxt = index_c;
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        bus.fifo_enable = !bus.fifo_full;
        bus.fifo_data   = hdr_word;
        if (!bus.fifo_full) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        bus.req_ready[grant_id] = !bus.fifo_full;
        xfer                    = bus.req_valid[grant_id] & !bus.fifo_full;
        bus.fifo_enable         = xfer;
        bus.fifo_data           = {lastw, cur_data};
        if (xfer) begin
          if (lastw) begin
            // Packet closes; a forced close (no requester last) is flagged next cycle.
            state_nxt    = ST_IDLE;
            rr_ptr_nxt   = grant_id;
            count_nxt    = '0;
            overlong_nxt = !bus.req_last[grant_id];
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= IDW'(N_REQ - 1);
      grant_id <= '0;
      count    <= '0;
      overlong <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
      count    <= count_nxt;
      overlong <= overlong_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector tables, directed corner
// sequences and a randomized run against a packet-level reference model.
module tb_fifo_write_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] grant_id;
  logic busy, overlong;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus();

  fifo_write_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .MAX_PKT_LEN(MAXL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .grant_id(grant_id), .busy(busy), .overlong(overlong)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.fifo_full = f;
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance to next posedge+1.
  task automatic step(input string nm, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic f, input logic en,
                      input logic [8:0] data, input logic [3:0] rdy, input logic bsy);
    set_in(v, l, d, f);
    #4;
    chk({nm, "_en"}, 32'(bus.fifo_enable), 32'(en));
    if (en) chk({nm, "_data"}, 32'(bus.fifo_data), 32'(data));
    chk({nm, "_rdy"}, 32'(bus.req_ready), 32'(rdy));
    chk({nm, "_busy"}, 32'(busy), 32'(bsy));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_in('0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(bus.fifo_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ovl", 32'(overlong), 0);
    chk("rst_rdy", 32'(bus.req_ready), 0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic        en;
    logic [8:0]  data;
    logic [3:0]  rdy;
    logic        bsy;
  } vec_t;

  vec_t tab[$];

  typedef struct {
    logic [7:0] d;
    bit         last;
  } w_t;

  w_t q[N][$];

  initial begin
    // Requester 0 single packet, then a packet stalled by fifo_full in HDR and XFER.
    tab.push_back('{4'h1, 4'h0, 32'hA1, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0});
    tab.push_back('{4'h1, 4'h0, 32'hA1, 1'b0, 1'b1, 9'h080, 4'h0, 1'b1});
    tab.push_back('{4'h1, 4'h0, 32'hA1, 1'b0, 1'b1, 9'h0A1, 4'h1, 1'b1});
    tab.push_back('{4'h1, 4'h0, 32'hA2, 1'b0, 1'b1, 9'h0A2, 4'h1, 1'b1});
    tab.push_back('{4'h1, 4'h1, 32'hA3, 1'b0, 1'b1, 9'h1A3, 4'h1, 1'b1});
    tab.push_back('{4'h0, 4'h0, 32'h00, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0});
    tab.push_back('{4'h1, 4'h0, 32'hB1, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0});
    tab.push_back('{4'h1, 4'h0, 32'hB1, 1'b1, 1'b0, 9'h000, 4'h0, 1'b1});
    tab.push_back('{4'h1, 4'h0, 32'hB1, 1'b0, 1'b1, 9'h080, 4'h0, 1'b1});
    tab.push_back('{4'h1, 4'h0, 32'hB1, 1'b0, 1'b1, 9'h0B1, 4'h1, 1'b1});
    tab.push_back('{4'h1, 4'h0, 32'hB2, 1'b1, 1'b0, 9'h000, 4'h0, 1'b1});
    tab.push_back('{4'h1, 4'h0, 32'hB2, 1'b1, 1'b0, 9'h000, 4'h0, 1'b1});
    tab.push_back('{4'h1, 4'h0, 32'hB2, 1'b1, 1'b0, 9'h000, 4'h0, 1'b1});
    tab.push_back('{4'h1, 4'h0, 32'hB2, 1'b0, 1'b1, 9'h0B2, 4'h1, 1'b1});
    tab.push_back('{4'h1, 4'h1, 32'hB3, 1'b0, 1'b1, 9'h1B3, 4'h1, 1'b1});
    tab.push_back('{4'h0, 4'h0, 32'h00, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0});

    do_reset();
    for (int i = 0; i < tab.size(); i++)
      step($sformatf("tab%0d", i), tab[i].v, tab[i].l, tab[i].d, tab[i].f,
           tab[i].en, tab[i].data, tab[i].rdy, tab[i].bsy);

    // Tie between requesters 1 and 2 straight after reset, then alternation.
    do_reset();
    step("tie_idle", 4'h6, 4'h6, 32'h00221100, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0);
    step("tie_h1",   4'h6, 4'h6, 32'h00221100, 1'b0, 1'b1, 9'h081, 4'h0, 1'b1);
    chk("tie_gid1", 32'(grant_id), 1);
    step("tie_w1",   4'h6, 4'h6, 32'h00221100, 1'b0, 1'b1, 9'h111, 4'h2, 1'b1);
    step("tie_gap",  4'h6, 4'h6, 32'h00221100, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0);
    step("tie_h2",   4'h6, 4'h6, 32'h00221100, 1'b0, 1'b1, 9'h082, 4'h0, 1'b1);
    chk("tie_gid2", 32'(grant_id), 2);
    step("tie_w2",   4'h6, 4'h6, 32'h00221100, 1'b0, 1'b1, 9'h122, 4'h4, 1'b1);
    step("tie_gap2", 4'h6, 4'h6, 32'h00221100, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0);
    step("tie_h3",   4'h6, 4'h6, 32'h00221100, 1'b0, 1'b1, 9'h081, 4'h0, 1'b1);
    step("tie_w3",   4'h2, 4'h2, 32'h00221100, 1'b0, 1'b1, 9'h111, 4'h2, 1'b1);
    step("tie_end",  4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 9'h000, 4'h0, 1'b0);

    // Requester 3 overruns MAX_PKT_LEN: forced last, overlong pulse, new header.
    step("ovl_idle", 4'h8, 4'h0, 32'h31000000, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0);
    step("ovl_h1",   4'h8, 4'h0, 32'h31000000, 1'b0, 1'b1, 9'h083, 4'h0, 1'b1);
    step("ovl_w1",   4'h8, 4'h0, 32'h31000000, 1'b0, 1'b1, 9'h031, 4'h8, 1'b1);
    step("ovl_w2",   4'h8, 4'h0, 32'h32000000, 1'b0, 1'b1, 9'h032, 4'h8, 1'b1);
    step("ovl_w3",   4'h8, 4'h0, 32'h33000000, 1'b0, 1'b1, 9'h033, 4'h8, 1'b1);
    chk("ovl_pre", 32'(overlong), 0);
    step("ovl_w4",   4'h8, 4'h0, 32'h34000000, 1'b0, 1'b1, 9'h134, 4'h8, 1'b1);
    chk("ovl_pulse", 32'(overlong), 1);
    step("ovl_gap",  4'h8, 4'h0, 32'h35000000, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0);
    chk("ovl_clear", 32'(overlong), 0);
    step("ovl_h2",   4'h8, 4'h0, 32'h35000000, 1'b0, 1'b1, 9'h083, 4'h0, 1'b1);
    step("ovl_w5",   4'h8, 4'h0, 32'h35000000, 1'b0, 1'b1, 9'h035, 4'h8, 1'b1);
    step("ovl_w6",   4'h8, 4'h8, 32'h36000000, 1'b0, 1'b1, 9'h136, 4'h8, 1'b1);
    step("ovl_end",  4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 9'h000, 4'h0, 1'b0);

    // Reset pulse in the middle of XFER; rr order restarts at requester 0.
    do_reset();
    step("rmx_idle", 4'h2, 4'h0, 32'h0000D100, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0);
    step("rmx_h",    4'h2, 4'h0, 32'h0000D100, 1'b0, 1'b1, 9'h081, 4'h0, 1'b1);
    step("rmx_w1",   4'h2, 4'h0, 32'h0000D100, 1'b0, 1'b1, 9'h0D1, 4'h2, 1'b1);
    set_in(4'h2, 4'h0, 32'h0000D200, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmx_en",   32'(bus.fifo_enable), 0);
    chk("rmx_busy", 32'(busy), 0);
    chk("rmx_rdy",  32'(bus.req_ready), 0);
    chk("rmx_gid",  32'(grant_id), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("rmx_idle2", 4'h3, 4'h0, 32'h0000D2C1, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0);
    step("rmx_h2",    4'h3, 4'h0, 32'h0000D2C1, 1'b0, 1'b1, 9'h080, 4'h0, 1'b1);
    step("rmx_w2",    4'h3, 4'h1, 32'h0000D2C1, 1'b0, 1'b1, 9'h1C1, 4'h1, 1'b1);
    step("rmx_end",   4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 9'h000, 4'h0, 1'b0);

    // Randomized traffic against a packet-level model.
    do_reset();
    begin
      int mode;       // 0: arbitrating, 1: header owed, 2: payload of owner
      int owner, last_win, nwords;
      logic [1:0] exp_gid;
      logic exp_ov;
      logic [3:0] v, l, erdy;
      logic [31:0] d;
      logic f, een, x, forced, lw;
      logic [8:0] edata;
      mode = 0; owner = 0; last_win = N - 1; nwords = 0; exp_gid = '0; exp_ov = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        for (int i = 0; i < N; i++) begin
          if (q[i].size() == 0) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++)
              q[i].push_back('{d: 8'($urandom), last: (k == len - 1)});
          end
          v[i] = ($urandom_range(0, 3) != 0);
          l[i] = q[i][0].last;
          d[i*DW +: DW] = q[i][0].d;
        end
        f = ($urandom_range(0, 4) == 0);
        set_in(v, l, d, f);

        een = 1'b0; edata = '0; erdy = '0; x = 1'b0; forced = 1'b0; lw = 1'b0;
        if (mode == 1) begin
          een   = !f;
          edata = 9'h080 | 9'(owner);
        end else if (mode == 2) begin
          erdy   = f ? 4'h0 : 4'(1 << owner);
          x      = v[owner] && !f;
          forced = (nwords == MAXL - 1);
          lw     = l[owner] || forced;
          een    = x;
          edata  = {lw, d[owner*DW +: DW]};
        end

        #4;
        chk("rnd_en", 32'(bus.fifo_enable), 32'(een));
        if (een) chk("rnd_data", 32'(bus.fifo_data), 32'(edata));
        chk("rnd_rdy", 32'(bus.req_ready), 32'(erdy));
        chk("rnd_busy", 32'(busy), 32'(mode != 0));
        chk("rnd_gid", 32'(grant_id), 32'(exp_gid));
        chk("rnd_ovl", 32'(overlong), 32'(exp_ov));
        @(posedge clk);

        exp_ov = 1'b0;
        if (mode == 0) begin
          if (v != 0) begin
            for (int k = 1; k <= N; k++) begin
              if (v[(last_win + k) % N]) begin
                owner = (last_win + k) % N;
                break;
              end
            end
            exp_gid = 2'(owner);
            mode = 1;
          end
        end else if (mode == 1) begin
          if (!f) begin
            mode = 2;
            nwords = 0;
          end
        end else if (x) begin
          void'(q[owner].pop_front());
          nwords++;
          if (lw) begin
            exp_ov   = forced && !l[owner];
            last_win = owner;
            mode     = 0;
          end
        end
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
